scan_seq_ctrl: RTL and testbench

Sequencer for the seven-chain scan/boundary-scan test wrapper. It drives `scan_en`, `test_en` and the seven serial scan inputs from a streamed pattern source. It checks the seven serial scan outputs against streamed expected and mask data, and counts failing shift beats. It sits between the on-chip test-pattern source and the wrapped core's scan ports, with load of pattern p overlapped with unload of pattern p-1.

---
 rtl/scan_seq_pkg.sv | 19 +
 rtl/scan_resp_checker.sv | 84 ++++++++
 rtl/scan_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// scan_seq_pkg: shared types for the scan sequencer.
// Holds the FSM state enum, chain-count default and beat-index width.
package scan_seq_pkg;

  localparam int NUM_CHAINS_DEF = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic int beat_w(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/scan_resp_checker.sv
// scan_resp_checker: compares unloaded scan data against masked expects.
// In: clk, rst_n, clr, beat_vld, exp/mask/tags, so. Out: fail_cnt, first-fail.
module scan_resp_checker
  import scan_seq_pkg::*;
#(
  parameter int NUM_CHAINS = NUM_CHAINS_DEF,
  parameter int PAT_W      = 16,
  parameter int BW         = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  beat_vld,
  input  logic [NUM_CHAINS-1:0] exp_bits,
  input  logic [NUM_CHAINS-1:0] mask_bits,
  input  logic [PAT_W-1:0]      tag_pat,
  input  logic [BW-1:0]         tag_beat,
  input  logic [NUM_CHAINS-1:0] so,
  output logic [PAT_W-1:0]      fail_cnt,
  output logic                  ff_valid,
  output logic [PAT_W-1:0]      ff_pat,
  output logic [BW-1:0]         ff_beat,
  output logic [NUM_CHAINS-1:0] ff_vec
);

  logic                  s1_vld;
  logic [NUM_CHAINS-1:0] s1_exp;
  logic [NUM_CHAINS-1:0] s1_mask;
  logic [PAT_W-1:0]      s1_pat;
  logic [BW-1:0]         s1_beat;
  logic                  s2_vld;
  logic [NUM_CHAINS-1:0] s2_vec;
  logic [PAT_W-1:0]      s2_pat;
  logic [BW-1:0]         s2_beat;

  // s1 holds the beat launched last edge; so is
  // sampled at the edge the chain shifts it out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_exp   <= '0;
      s1_mask  <= '0;
      s1_pat   <= '0;
      s1_beat  <= '0;
      s2_vld   <= 1'b0;
      s2_vec   <= '0;
      s2_pat   <= '0;
      s2_beat  <= '0;
      fail_cnt <= '0;
      ff_valid <= 1'b0;
      ff_pat   <= '0;
      ff_beat  <= '0;
      ff_vec   <= '0;
    end else begin
      s1_vld <= beat_vld && !clr;
      if (beat_vld) begin
        s1_exp  <= exp_bits;
        s1_mask <= mask_bits;
        s1_pat  <= tag_pat;
        s1_beat <= tag_beat;
      end
      s2_vld  <= s1_vld && !clr;
      s2_vec  <= (so ^ s1_exp) & s1_mask;
      s2_pat  <= s1_pat;
      s2_beat <= s1_beat;
      if (clr) begin
        fail_cnt <= '0;
        ff_valid <= 1'b0;
        ff_pat   <= '0;
        ff_beat  <= '0;
        ff_vec   <= '0;
      end else if (s2_vld && |s2_vec) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (!ff_valid) begin
          ff_valid <= 1'b1;
          ff_pat   <= s2_pat;
          ff_beat  <= s2_beat;
          ff_vec   <= s2_vec;
        end
      end
    end
  end

endmodule

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: scan load/unload sequencer with overlapped response check.
// In: CK, RSTN, start, abort, num_patterns, pat_* stream, SO_chain.
// Out: pat_ready, SI_chain, scan_en, test_en, busy, done, underrun, fail data.
module scan_seq_ctrl
  import scan_seq_pkg::*;
#(
  parameter int  NUM_CHAINS = NUM_CHAINS_DEF,
  parameter int  CHAIN_LEN  = 43,
  parameter int  PAT_W      = 16,
  localparam int BW         = beat_w(CHAIN_LEN)
) (
  input  logic                  CK,
  input  logic                  RSTN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PAT_W-1:0]      num_patterns,
  input  logic                  pat_valid,
  output logic                  pat_ready,
  input  logic [NUM_CHAINS-1:0] pat_si,
  input  logic [NUM_CHAINS-1:0] pat_exp,
  input  logic [NUM_CHAINS-1:0] pat_mask,
  output logic [NUM_CHAINS-1:0] SI_chain,
  input  logic [NUM_CHAINS-1:0] SO_chain,
  output logic                  scan_en,
  output logic                  test_en,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  output logic [PAT_W-1:0]      fail_cnt,
  output logic                  first_fail_valid,
  output logic [PAT_W-1:0]      first_fail_pat,
  output logic [BW-1:0]         first_fail_beat,
  output logic [NUM_CHAINS-1:0] first_fail_vec
);

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q;
  logic [PAT_W-1:0]      pat_q;
  logic [PAT_W-1:0]      npat_q;
  logic                  shifting;
  logic                  go;
  logic                  beat_ok;
  logic                  hole;
  logic                  last_beat;
  logic                  pat_more;
  logic [PAT_W:0]        pat_inc;
  logic [PAT_W-1:0]      tag_pat;
  logic [NUM_CHAINS-1:0] mask_eff;

  assign shifting  = (state_q == S_SHIFT) ||
                     (state_q == S_FLUSH);
  assign pat_ready = shifting;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign test_en   = scan_en;

  assign go        = start && !abort &&
                     (state_q == S_IDLE);
  assign beat_ok   = shifting && pat_valid && !abort;
  assign hole      = shifting && !pat_valid && !abort;
  assign last_beat = (beat_q == BW'(CHAIN_LEN - 1));
  assign pat_inc   = {1'b0, pat_q} + 1'b1;
  assign pat_more  = (pat_inc < {1'b0, npat_q});

  // Unload of load p belongs to pattern p-1; in FLUSH p==N.
  assign tag_pat  = pat_q - 1'b1;
  assign mask_eff = ((state_q == S_SHIFT) && (pat_q == '0))
                  ? '0 : pat_mask;

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (start)
            state_d = (num_patterns == '0) ? S_DONE : S_SHIFT;
        S_SHIFT:
          if (!pat_valid)     state_d = S_IDLE;
          else if (last_beat) state_d = S_CAPTURE;
        S_CAPTURE:
          state_d = pat_more ? S_SHIFT : S_FLUSH;
        S_FLUSH:
          if (!pat_valid)     state_d = S_IDLE;
          else if (last_beat) state_d = S_DONE;
        S_DONE:
          state_d = S_IDLE;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  // scan_en follows accepted beats one edge later, so the
  // gap after the last load beat is the capture cycle.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      pat_q    <= '0;
      npat_q   <= '0;
      underrun <= 1'b0;
      scan_en  <= 1'b0;
      SI_chain <= '0;
    end else begin
      state_q  <= state_d;
      scan_en  <= beat_ok;
      SI_chain <= '0;
      if (beat_ok && (state_q == S_SHIFT)) SI_chain <= pat_si;
      if (go) begin
        npat_q   <= num_patterns;
        pat_q    <= '0;
        beat_q   <= '0;
        underrun <= 1'b0;
      end
      if (beat_ok) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      if ((state_q == S_CAPTURE) && !abort)
        pat_q <= pat_inc[PAT_W-1:0];
      if (hole) underrun <= 1'b1;
    end
  end

  scan_resp_checker #(
    .NUM_CHAINS (NUM_CHAINS),
    .PAT_W      (PAT_W),
    .BW         (BW)
  ) u_chk (
    .clk       (CK),
    .rst_n     (RSTN),
    .clr       (go),
    .beat_vld  (beat_ok),
    .exp_bits  (pat_exp),
    .mask_bits (mask_eff),
    .tag_pat   (tag_pat),
    .tag_beat  (beat_q),
    .so        (SO_chain),
    .fail_cnt  (fail_cnt),
    .ff_valid  (first_fail_valid),
    .ff_pat    (first_fail_pat),
    .ff_beat   (first_fail_beat),
    .ff_vec    (first_fail_vec)
  );

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb_scan_seq_ctrl: scoreboard bench with a 7-chain shift-register core model.
// Second instance with PAT_W=2 exercises fail counter saturation.
module tb_scan_seq_ctrl;

  localparam int NC = 7;
  localparam int L  = 4;
  localparam int PW = 16;
  localparam int BW = 2;

  logic          CK = 1'b0;
  logic          RSTN = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] num_patterns = '0;
  logic          pat_valid = 1'b0;
  logic [NC-1:0] pat_si = '0;
  logic [NC-1:0] pat_exp = '0;
  logic [NC-1:0] pat_mask = '0;
  logic [NC-1:0] SO_chain;

  logic          pat_ready;
  logic [NC-1:0] SI_chain;
  logic          scan_en, test_en, busy, done, underrun;
  logic [PW-1:0] fail_cnt;
  logic          first_fail_valid;
  logic [PW-1:0] first_fail_pat;
  logic [BW-1:0] first_fail_beat;
  logic [NC-1:0] first_fail_vec;

  logic          s_ready, s_sen, s_ten, s_busy, s_done, s_und, s_ffv;
  logic [NC-1:0] s_si, s_ffvec;
  logic [1:0]    s_fail_cnt, s_ffp;
  logic [BW-1:0] s_ffb;

  int tot = 0;
  int bad = 0;

  always #5 CK = ~CK;

  scan_seq_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .PAT_W(PW)) dut (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort),
    .num_patterns(num_patterns), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .pat_si(pat_si), .pat_exp(pat_exp),
    .pat_mask(pat_mask), .SI_chain(SI_chain), .SO_chain(SO_chain),
    .scan_en(scan_en), .test_en(test_en), .busy(busy), .done(done),
    .underrun(underrun), .fail_cnt(fail_cnt),
    .first_fail_valid(first_fail_valid),
    .first_fail_pat(first_fail_pat),
    .first_fail_beat(first_fail_beat),
    .first_fail_vec(first_fail_vec)
  );

  scan_seq_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .PAT_W(2)) dut_sat (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort),
    .num_patterns(num_patterns[1:0]), .pat_valid(pat_valid),
    .pat_ready(s_ready), .pat_si(pat_si), .pat_exp(pat_exp),
    .pat_mask(pat_mask), .SI_chain(s_si), .SO_chain(SO_chain),
    .scan_en(s_sen), .test_en(s_ten), .busy(s_busy), .done(s_done),
    .underrun(s_und), .fail_cnt(s_fail_cnt),
    .first_fail_valid(s_ffv), .first_fail_pat(s_ffp),
    .first_fail_beat(s_ffb), .first_fail_vec(s_ffvec)
  );

  // Core model: shift in at bit 0, SO from bit L-1; the
  // capture edge (scan_en falls) loads the inverted chain.
  logic [L-1:0] ch [NC] = '{default: '0};
  logic         sen_d = 1'b0;
  int           cap_cnt = 0;
  int           inj_pat = -1;
  logic [L-1:0] flipv = '0;

  always @(posedge CK) begin
    if (start && !busy) cap_cnt <= 0;
    else if (!scan_en && sen_d) cap_cnt <= cap_cnt + 1;
    sen_d <= scan_en;
    for (int c = 0; c < NC; c++) begin
      if (scan_en)
        ch[c] <= {ch[c][L-2:0], SI_chain[c]};
      else if (sen_d)
        ch[c] <= ~ch[c] ^ ((c == 2 && cap_cnt == inj_pat) ? flipv : '0);
    end
  end

  always_comb begin
    SO_chain = '0;
    for (int c = 0; c < NC; c++) SO_chain[c] = ch[c][L-1];
  end

  // Scoreboard: launched SI per accepted beat.
  logic [NC-1:0] sbq [$];
  logic [NC-1:0] mon_e;

  always @(negedge CK) begin
    if (RSTN && scan_en) begin
      tot++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL si_sb: scan_en=1 but no beat queued");
      end else begin
        mon_e = sbq.pop_front();
        if ({test_en, SI_chain} !== {1'b1, mon_e}) begin
          bad++;
          $display("FAIL si_sb: te/si got %b/%h want 1/%h",
                   test_en, SI_chain, mon_e);
        end
      end
    end
  end

  logic [NC-1:0] si [0:7][0:L-1];

  task automatic run(input int n, input logic [NC-1:0] msk,
                     input int nbad, input int drop_b,
                     input int abort_b, input int rst_b,
                     output int dcyc, output bit gdone,
                     output bit gund, output bit sen_seen);
    int b, lp, k, cyc;
    bit fin;
    for (int p = 0; p < n; p++)
      for (int j = 0; j < L; j++) si[p][j] = NC'($urandom);
    gdone = 0; gund = 0; dcyc = -1; sen_seen = 0;
    fin = 0; b = 0; cyc = 0;
    @(negedge CK);
    num_patterns = PW'(n);
    start = 1'b1;
    pat_valid = 1'b1;
    while (!fin) begin
      @(negedge CK);
      start = 1'b0;
      abort = 1'b0;
      cyc++;
      if (scan_en) sen_seen = 1;
      if (done) begin
        gdone = 1; dcyc = cyc; fin = 1;
      end else if (!busy) begin
        gund = underrun; fin = 1;
      end else if (cyc > 200) begin
        tot++; bad++;
        $display("FAIL timeout: no done after %0d cycles", cyc);
        fin = 1;
      end else if (b == rst_b) begin
        #1 RSTN = 1'b0;
        fin = 1;
      end else begin
        lp = b / L;
        k  = b % L;
        pat_si  = (lp < n) ? si[lp][k] : NC'($urandom);
        pat_exp = (lp > 0) ? ~si[lp-1][k] : NC'($urandom);
        if (lp > 0 && b - L < nbad) pat_exp = pat_exp ^ 7'h01;
        pat_mask  = msk;
        pat_valid = (b != drop_b);
        abort     = (b == abort_b) && pat_ready;
        if (pat_valid && pat_ready && !abort) begin
          sbq.push_back((lp < n) ? si[lp][k] : '0);
          b++;
        end
      end
    end
    pat_valid = 1'b0;
  endtask

  int dc; bit gd, gu, ss;

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(negedge CK);
    tot++;
    if ({scan_en, test_en, busy, done, underrun} !== 5'b0) begin
      bad++;
      $display("FAIL rst_flags: got %b want 00000",
               {scan_en, test_en, busy, done, underrun});
    end
    tot++;
    if ({pat_ready, SI_chain} !== '0) begin
      bad++;
      $display("FAIL rst_si: got %b/%h want 0/0", pat_ready, SI_chain);
    end
    tot++;
    if ({fail_cnt, first_fail_valid, first_fail_pat,
         first_fail_beat, first_fail_vec} !== '0) begin
      bad++;
      $display("FAIL rst_fail: cnt %0d ffv %b want 0/0",
               fail_cnt, first_fail_valid);
    end
    RSTN = 1'b1;
    @(negedge CK);
  endtask

  task automatic test_clean();
    run(2, 7'h7f, 0, -1, -1, -1, dc, gd, gu, ss);
    tot++;
    if (!gd || dc != 3 * (L + 1)) begin
      bad++;
      $display("FAIL clean_len: done=%b cyc %0d want 1/%0d",
               gd, dc, 3 * (L + 1));
    end
    @(negedge CK);
    tot++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clean_pulse: done/busy %b/%b want 0/0", done, busy);
    end
    @(negedge CK);
    tot++;
    if (fail_cnt !== 0 || first_fail_valid !== 1'b0) begin
      bad++;
      $display("FAIL clean_res: cnt %0d ffv %b want 0/0",
               fail_cnt, first_fail_valid);
    end
    tot++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL clean_sb: %0d beats left want 0", sbq.size());
    end
  endtask

  task automatic test_single_error(input logic [NC-1:0] msk,
                                   input int want_cnt);
    inj_pat = 1;
    flipv = L'(1) << (L - 1 - 2);
    run(3, msk, 0, -1, -1, -1, dc, gd, gu, ss);
    inj_pat = -1;
    tot++;
    if (!gd || dc != 4 * (L + 1)) begin
      bad++;
      $display("FAIL err_len: done=%b cyc %0d want 1/%0d",
               gd, dc, 4 * (L + 1));
    end
    repeat (2) @(negedge CK);
    tot++;
    if (fail_cnt !== PW'(want_cnt)) begin
      bad++;
      $display("FAIL err_cnt: got %0d want %0d", fail_cnt, want_cnt);
    end
    tot++;
    if (first_fail_valid !== (want_cnt != 0)) begin
      bad++;
      $display("FAIL err_ffv: got %b want %b",
               first_fail_valid, want_cnt != 0);
    end
    if (want_cnt != 0) begin
      tot++;
      if ({first_fail_pat, first_fail_beat, first_fail_vec} !==
          {16'd1, 2'd2, 7'h04}) begin
        bad++;
        $display("FAIL err_ff: pat %0d beat %0d vec %h want 1 2 04",
                 first_fail_pat, first_fail_beat, first_fail_vec);
      end
    end
  endtask

  task automatic test_saturation();
    run(2, 7'h7f, 5, -1, -1, -1, dc, gd, gu, ss);
    repeat (2) @(negedge CK);
    tot++;
    if (fail_cnt !== 16'd5 || s_fail_cnt !== 2'd3) begin
      bad++;
      $display("FAIL sat_cnt: got %0d/%0d want 5/3",
               fail_cnt, s_fail_cnt);
    end
    tot++;
    if ({first_fail_valid, first_fail_pat, first_fail_beat,
         first_fail_vec} !== {1'b1, 16'd0, 2'd0, 7'h01}) begin
      bad++;
      $display("FAIL sat_ff: v %b pat %0d beat %0d vec %h want 1 0 0 01",
               first_fail_valid, first_fail_pat, first_fail_beat,
               first_fail_vec);
    end
  endtask

  task automatic test_zero();
    run(0, 7'h7f, 0, -1, -1, -1, dc, gd, gu, ss);
    tot++;
    if (!gd || dc != 1 || ss) begin
      bad++;
      $display("FAIL zero: done=%b cyc %0d sen %b want 1/1/0",
               gd, dc, ss);
    end
    @(negedge CK);
    tot++;
    if (done !== 1'b0 || busy !== 1'b0 || fail_cnt !== 0) begin
      bad++;
      $display("FAIL zero_end: done/busy/cnt %b/%b/%0d want 0/0/0",
               done, busy, fail_cnt);
    end
  endtask

  task automatic test_underrun();
    run(2, 7'h7f, 0, 2 * L + 1, -1, -1, dc, gd, gu, ss);
    tot++;
    if (gd || !gu || busy !== 1'b0 || scan_en !== 1'b0) begin
      bad++;
      $display("FAIL und: done %b und %b busy %b sen %b want 0 1 0 0",
               gd, gu, busy, scan_en);
    end
    repeat (2) @(negedge CK);
    tot++;
    if (underrun !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL und_sticky: und/done %b/%b want 1/0",
               underrun, done);
    end
  endtask

  task automatic test_abort();
    run(2, 7'h7f, 1, -1, L + 2, -1, dc, gd, gu, ss);
    tot++;
    if (gd || busy !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL abort: done %b busy %b und %b want 0 0 0",
               gd, busy, underrun);
    end
    repeat (2) @(negedge CK);
    tot++;
    if (fail_cnt !== 16'd1 || first_fail_valid !== 1'b1) begin
      bad++;
      $display("FAIL abort_hold: cnt %0d ffv %b want 1/1",
               fail_cnt, first_fail_valid);
    end
  endtask

  task automatic test_reset_mid();
    run(2, 7'h7f, 1, -1, -1, L + 3, dc, gd, gu, ss);
    #1;
    tot++;
    if ({scan_en, test_en, busy, done, pat_ready, SI_chain} !== '0) begin
      bad++;
      $display("FAIL rst_mid: sen %b te %b busy %b done %b si %h want 0",
               scan_en, test_en, busy, done, SI_chain);
    end
    tot++;
    if (fail_cnt !== 0 || first_fail_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_cnt: cnt %0d ffv %b want 0/0",
               fail_cnt, first_fail_valid);
    end
    sbq.delete();
    @(negedge CK);
    RSTN = 1'b1;
    @(negedge CK);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      run(1, 7'h7f, 0, -1, -1, -1, dc, gd, gu, ss);
      tot++;
      if (!gd || dc != 2 * (L + 1)) begin
        bad++;
        $display("FAIL b2b_len%0d: done=%b cyc %0d want 1/%0d",
                 r, gd, dc, 2 * (L + 1));
      end
    end
    repeat (2) @(negedge CK);
    tot++;
    if (fail_cnt !== 0 || underrun !== 1'b0 || sbq.size() != 0) begin
      bad++;
      $display("FAIL b2b_res: cnt %0d und %b q %0d want 0 0 0",
               fail_cnt, underrun, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error(7'h7f, 1);
    test_single_error(7'h7b, 0);
    test_saturation();
    test_zero();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
